// File: rtl/wr_sched_pkg.sv
`default_nettype none
// ============================================================================
// wr_sched_pkg : shared AXI write-scheduler types, widths and master indices
// Revision     : 1.0 - initial release
// ============================================================================
package wr_sched_pkg;

    localparam int AXI_LEN_BITS = 4;
    localparam int SLV_BITS     = 3;
    localparam int DEF_NUM_SLV  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_e;

    localparam logic [1:0] MST_NONE = 2'd0;
    localparam logic [1:0] MST_M1   = 2'd1;
    localparam logic [1:0] MST_M2   = 2'd2;

    localparam logic [SLV_BITS-1:0] SLV_SD = SLV_BITS'(DEF_NUM_SLV - 1);

endpackage
`default_nettype wire

// File: rtl/wr_sched_rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2  : two-way round-robin selector, one-hot grant {M2, M1}
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       i_req1,
    input  logic       i_req2,
    input  logic       i_ptr,    // 1 = M2 has priority on a tie
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            if (i_req1 && i_req2) begin
                o_gnt = i_ptr ? 2'b10 : 2'b01;
            end else if (i_req1) begin
                o_gnt = 2'b01;
            end else if (i_req2) begin
                o_gnt = 2'b10;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wr_sched.sv
`default_nettype none
// ============================================================================
// wr_sched : single-outstanding AXI write scheduler (AW arbitration, W routing,
//            B wait) for two masters.
// Revision : 1.0 - initial release
// ============================================================================
module wr_sched
    import wr_sched_pkg::*;
#(
    parameter int NUM_SLV = DEF_NUM_SLV
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_m1_i,
    input  logic                    req_m2_i,
    input  logic [AXI_LEN_BITS-1:0] len_m1_i,
    input  logic [AXI_LEN_BITS-1:0] len_m2_i,
    input  logic [SLV_BITS-1:0]     slv_sel_i,
    input  logic                    aw_hs_i,
    input  logic                    w_hs_i,
    input  logic                    wlast_i,
    input  logic                    b_hs_i,
    output logic                    gnt_m1_o,
    output logic                    gnt_m2_o,
    output logic [1:0]              w_owner_o,
    output logic [SLV_BITS-1:0]     w_slv_o,
    output logic                    w_route_vld_o,
    output logic                    b_wait_o,
    output logic                    len_err_o
);

    localparam logic [SLV_BITS-1:0] c_SD = SLV_BITS'(NUM_SLV - 1);

    wr_state_e               r_state;
    wr_state_e               w_state_nxt;
    logic [1:0]              r_gnt;
    logic [1:0]              w_arb_gnt;
    logic                    w_arb_en;
    logic                    r_ptr;
    logic [1:0]              r_owner;
    logic [SLV_BITS-1:0]     r_slv;
    logic [SLV_BITS-1:0]     w_slv_sel;
    logic [AXI_LEN_BITS-1:0] r_len;
    logic [AXI_LEN_BITS:0]   r_cnt;
    logic                    r_len_err;
    logic                    w_aw_acc;
    logic                    w_beat;
    logic                    w_cnt_at_len;
    logic                    w_err;

    assign w_arb_en     = (r_state == ST_IDLE);
    assign w_aw_acc     = (r_state == ST_ADDR) && aw_hs_i;
    assign w_beat       = (r_state == ST_DATA) && w_hs_i;
    assign w_cnt_at_len = (r_cnt == {1'b0, r_len});
    // WLAST must land exactly on beat len; a non-last beat at len is an overrun
    assign w_err        = w_beat && (wlast_i ? !w_cnt_at_len : w_cnt_at_len);
    // Out-of-range decodes fall back to the default slave
    assign w_slv_sel    = (slv_sel_i > c_SD) ? c_SD : slv_sel_i;

    rr_arb2 u_arb (
        .i_req1 (req_m1_i),
        .i_req2 (req_m2_i),
        .i_ptr  (r_ptr),
        .i_en   (w_arb_en),
        .o_gnt  (w_arb_gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (req_m1_i || req_m2_i) w_state_nxt = ST_ADDR;
            ST_ADDR: if (aw_hs_i)              w_state_nxt = ST_DATA;
            ST_DATA: if (w_hs_i && wlast_i)    w_state_nxt = ST_RESP;
            ST_RESP: if (b_hs_i)               w_state_nxt = ST_IDLE;
            default:                           w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt     <= 2'b00;
            r_ptr     <= 1'b0;
            r_owner   <= MST_NONE;
            r_slv     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_len_err <= 1'b0;
        end else begin
            r_len_err <= w_err;
            if (r_state == ST_IDLE) begin
                r_gnt <= w_arb_gnt;
            end else if (w_aw_acc) begin
                r_gnt <= 2'b00;
            end
            if (w_aw_acc) begin
                r_slv   <= w_slv_sel;
                r_owner <= r_gnt[0] ? MST_M1 : MST_M2;
                r_len   <= r_gnt[0] ? len_m1_i : len_m2_i;
                r_cnt   <= '0;
                // Point away from the master just served
                r_ptr   <= r_gnt[0];
            end
            if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == ST_RESP) && b_hs_i) begin
                r_owner <= MST_NONE;
            end
        end
    end

    assign gnt_m1_o      = r_gnt[0];
    assign gnt_m2_o      = r_gnt[1];
    assign w_owner_o     = r_owner;
    assign w_slv_o       = r_slv;
    assign w_route_vld_o = (r_state == ST_DATA);
    assign b_wait_o      = (r_state == ST_RESP);
    assign len_err_o     = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_wr_sched.sv
`default_nettype none
// ============================================================================
// tb_wr_sched : vector-table and scoreboard bench for wr_sched
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wr_sched;
    import wr_sched_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    req_m1_i, req_m2_i;
    logic [AXI_LEN_BITS-1:0] len_m1_i, len_m2_i;
    logic [SLV_BITS-1:0]     slv_sel_i;
    logic                    aw_hs_i, w_hs_i, wlast_i, b_hs_i;
    logic                    gnt_m1_o, gnt_m2_o;
    logic [1:0]              w_owner_o;
    logic [SLV_BITS-1:0]     w_slv_o;
    logic                    w_route_vld_o, b_wait_o, len_err_o;

    wr_sched #(.NUM_SLV(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_m1_i      (req_m1_i),
        .req_m2_i      (req_m2_i),
        .len_m1_i      (len_m1_i),
        .len_m2_i      (len_m2_i),
        .slv_sel_i     (slv_sel_i),
        .aw_hs_i       (aw_hs_i),
        .w_hs_i        (w_hs_i),
        .wlast_i       (wlast_i),
        .b_hs_i        (b_hs_i),
        .gnt_m1_o      (gnt_m1_o),
        .gnt_m2_o      (gnt_m2_o),
        .w_owner_o     (w_owner_o),
        .w_slv_o       (w_slv_o),
        .w_route_vld_o (w_route_vld_o),
        .b_wait_o      (b_wait_o),
        .len_err_o     (len_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                    r1;
        logic                    r2;
        logic [AXI_LEN_BITS-1:0] l1;
        logic [AXI_LEN_BITS-1:0] l2;
        logic [SLV_BITS-1:0]     sel;
        logic                    aw;
        logic                    w;
        logic                    wl;
        logic                    b;
    } in_t;

    typedef struct packed {
        logic                g1;
        logic                g2;
        logic [1:0]          own;
        logic [SLV_BITS-1:0] slv;
        logic                rv;
        logic                bw;
        logic                er;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    vec_t  vecs[$];
    out_t  exp_q[$];
    string name_q[$];
    int    n_pass  = 0;
    int    n_total = 0;

    function automatic in_t vi(input int r1, input int r2, input int l1, input int l2,
                               input int sel, input int aw, input int w, input int wl,
                               input int b);
        in_t v;
        v.r1  = r1[0];
        v.r2  = r2[0];
        v.l1  = l1[AXI_LEN_BITS-1:0];
        v.l2  = l2[AXI_LEN_BITS-1:0];
        v.sel = sel[SLV_BITS-1:0];
        v.aw  = aw[0];
        v.w   = w[0];
        v.wl  = wl[0];
        v.b   = b[0];
        return v;
    endfunction

    function automatic out_t vo(input int g1, input int g2, input int own, input int slv,
                                input int rv, input int bw, input int er);
        out_t o;
        o.g1  = g1[0];
        o.g2  = g2[0];
        o.own = own[1:0];
        o.slv = slv[SLV_BITS-1:0];
        o.rv  = rv[0];
        o.bw  = bw[0];
        o.er  = er[0];
        return o;
    endfunction

    function automatic out_t act();
        out_t a;
        a.g1  = gnt_m1_o;
        a.g2  = gnt_m2_o;
        a.own = w_owner_o;
        a.slv = w_slv_o;
        a.rv  = w_route_vld_o;
        a.bw  = b_wait_o;
        a.er  = len_err_o;
        return a;
    endfunction

    task automatic chk(input string n, input out_t a, input out_t e);
        n_total++;
        if (a === e) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual g1=%b g2=%b own=%0d slv=%0d rv=%b bw=%b er=%b, required g1=%b g2=%b own=%0d slv=%0d rv=%b bw=%b er=%b",
                     n, a.g1, a.g2, a.own, a.slv, a.rv, a.bw, a.er,
                     e.g1, e.g2, e.own, e.slv, e.rv, e.bw, e.er);
        end
    endtask

    task automatic drive(input in_t v);
        req_m1_i  = v.r1;
        req_m2_i  = v.r2;
        len_m1_i  = v.l1;
        len_m2_i  = v.l2;
        slv_sel_i = v.sel;
        aw_hs_i   = v.aw;
        w_hs_i    = v.w;
        wlast_i   = v.wl;
        b_hs_i    = v.b;
    endtask

    // Drive on the falling edge, score one cycle later just after the rising edge
    task automatic apply(input string n, input in_t i, input out_t o);
        out_t  e;
        string en;
        @(negedge clk);
        drive(i);
        exp_q.push_back(o);
        name_q.push_back(n);
        @(posedge clk);
        #1;
        e  = exp_q.pop_front();
        en = name_q.pop_front();
        chk(en, act(), e);
    endtask

    task automatic addv(input string n, input in_t i, input out_t o);
        vec_t v;
        v.name = n;
        v.i    = i;
        v.o    = o;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int slv_prev;
        out_t zero;
        zero = vo(0, 0, 0, 0, 0, 0, 0);

        // M1 write len=3 to S2 with a gap and ignored stray handshakes
        addv("A_gnt",       vi(1,0,3,0,2,0,0,0,0), vo(1,0,0,0,0,0,0));
        addv("A_hold",      vi(1,0,3,0,2,0,0,0,0), vo(1,0,0,0,0,0,0));
        addv("A_aw",        vi(1,0,3,0,2,1,0,0,0), vo(0,0,1,2,1,0,0));
        addv("A_beat1",     vi(0,0,3,0,2,0,1,0,0), vo(0,0,1,2,1,0,0));
        addv("A_beat2",     vi(0,0,3,0,2,0,1,0,0), vo(0,0,1,2,1,0,0));
        addv("A_gap",       vi(0,0,3,0,2,0,0,0,0), vo(0,0,1,2,1,0,0));
        addv("A_beat3",     vi(0,0,3,0,2,0,1,0,0), vo(0,0,1,2,1,0,0));
        addv("A_beat4last", vi(0,0,3,0,2,0,1,1,0), vo(0,0,1,2,0,1,0));
        addv("A_w_in_resp", vi(0,0,3,0,2,0,1,1,0), vo(0,0,1,2,0,1,0));
        addv("A_bresp",     vi(0,0,3,0,2,0,0,0,1), vo(0,0,0,2,0,0,0));
        addv("A_b_in_idle", vi(0,0,3,0,2,0,0,0,1), vo(0,0,0,2,0,0,0));
        // Tie after an M1 grant goes to M2; len=1 with WLAST on beat 1
        addv("B_gnt",       vi(1,1,0,1,5,0,0,0,0), vo(0,1,0,2,0,0,0));
        addv("B_aw",        vi(1,1,0,1,5,1,0,0,0), vo(0,0,2,5,1,0,0));
        addv("B_early",     vi(0,0,0,1,5,0,1,1,0), vo(0,0,2,5,0,1,1));
        addv("B_resp",      vi(0,0,0,1,5,0,0,0,0), vo(0,0,2,5,0,1,0));
        addv("B_b",         vi(0,0,0,1,5,0,0,0,1), vo(0,0,0,5,0,0,0));
        // len=0 with WLAST low on beat 1: overrun pulse, stay in DATA
        addv("C_gnt",       vi(1,1,0,0,1,0,0,0,0), vo(1,0,0,5,0,0,0));
        addv("C_aw",        vi(1,1,0,0,1,1,0,0,0), vo(0,0,1,1,1,0,0));
        addv("C_over",      vi(0,0,0,0,1,0,1,0,0), vo(0,0,1,1,1,0,1));
        addv("C_extra",     vi(0,0,0,0,1,0,1,0,0), vo(0,0,1,1,1,0,0));
        addv("C_wlast",     vi(0,0,0,0,1,0,1,1,0), vo(0,0,1,1,0,1,1));
        addv("C_b",         vi(0,0,0,0,1,0,0,0,1), vo(0,0,0,1,0,0,0));
        // SD slave, b_hs together with the WLAST beat is ignored
        addv("D_gnt",       vi(0,1,0,0,SLV_SD,0,0,0,0), vo(0,1,0,1,0,0,0));
        addv("D_aw",        vi(0,1,0,0,SLV_SD,1,0,0,0), vo(0,0,2,SLV_SD,1,0,0));
        addv("D_wlast_b",   vi(0,0,0,0,SLV_SD,0,1,1,1), vo(0,0,2,SLV_SD,0,1,0));
        addv("D_resp",      vi(0,0,0,0,SLV_SD,0,0,0,0), vo(0,0,2,SLV_SD,0,1,0));
        addv("D_b",         vi(0,0,0,0,SLV_SD,0,0,0,1), vo(0,0,0,SLV_SD,0,0,0));
        // M2 grant held across a 5-cycle AW stall while requests swap
        addv("E_gnt",       vi(0,1,0,2,3,0,0,0,0), vo(0,1,0,SLV_SD,0,0,0));
        for (int k = 0; k < 5; k++)
            addv("E_hold",  vi(1,0,0,2,3,0,0,0,0), vo(0,1,0,SLV_SD,0,0,0));
        addv("E_aw",        vi(1,0,0,2,3,1,0,0,0), vo(0,0,2,3,1,0,0));
        addv("E_beat1",     vi(0,0,0,2,3,0,1,0,0), vo(0,0,2,3,1,0,0));
        addv("E_beat2",     vi(0,0,0,2,3,0,1,0,0), vo(0,0,2,3,1,0,0));
        addv("E_beat3last", vi(0,0,0,2,3,0,1,1,0), vo(0,0,2,3,0,1,0));
        addv("E_b",         vi(0,0,0,2,3,0,0,0,1), vo(0,0,0,3,0,0,0));

        drive(vi(0,0,0,0,0,0,0,0,0));
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", act(), zero);
        @(negedge clk);
        req_m1_i = 1'b1;
        req_m2_i = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_holds_grant", act(), zero);
        @(negedge clk);
        drive(vi(0,0,0,0,0,0,0,0,0));
        rst = 1'b1;

        foreach (vecs[n]) apply(vecs[n].name, vecs[n].i, vecs[n].o);

        // Both masters requesting continuously, single-beat writes
        slv_prev = 3;
        for (int k = 0; k < 4; k++) begin
            int m1;
            m1 = ((k % 2) == 0) ? 1 : 0;
            apply("rr_gnt",  vi(1,1,0,0,k,0,0,0,0), vo(m1,1-m1,0,slv_prev,0,0,0));
            apply("rr_aw",   vi(1,1,0,0,k,1,0,0,0), vo(0,0,(m1 == 1) ? 1 : 2,k,1,0,0));
            apply("rr_last", vi(1,1,0,0,k,0,1,1,0), vo(0,0,(m1 == 1) ? 1 : 2,k,0,1,0));
            apply("rr_b",    vi(1,1,0,0,k,0,0,0,1), vo(0,0,0,k,0,0,0));
            slv_prev = k;
        end

        // Reset asserted in DATA after two beats, alongside a mismatching WLAST
        apply("X_gnt",   vi(1,0,3,0,4,0,0,0,0), vo(1,0,0,3,0,0,0));
        apply("X_aw",    vi(1,0,3,0,4,1,0,0,0), vo(0,0,1,4,1,0,0));
        apply("X_beat1", vi(0,0,3,0,4,0,1,0,0), vo(0,0,1,4,1,0,0));
        apply("X_beat2", vi(0,0,3,0,4,0,1,0,0), vo(0,0,1,4,1,0,0));
        @(negedge clk);
        drive(vi(0,0,3,0,4,0,1,1,0));
        rst = 1'b0;
        #1;
        chk("rst_async", act(), zero);
        @(posedge clk);
        #1;
        chk("rst_no_err", act(), zero);
        @(negedge clk);
        drive(vi(0,0,0,0,0,0,0,0,0));
        rst = 1'b1;
        // Pointer was left favouring M2; reset must restore M1 priority
        apply("Y_gnt",  vi(1,1,0,0,6,0,0,0,0), vo(1,0,0,0,0,0,0));
        apply("Y_aw",   vi(1,1,0,0,6,1,0,0,0), vo(0,0,1,6,1,0,0));
        apply("Y_last", vi(0,0,0,0,6,0,1,1,0), vo(0,0,1,6,0,1,0));
        apply("Y_b",    vi(0,0,0,0,6,0,0,0,1), vo(0,0,0,6,0,0,0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
